// File: rtl/ms_timer.sv
// ms_timer: millisecond countdown fed by the register-file timer fields.
// Reports a sticky done flag, a busy flag and a one-cycle irq on expiry.
module ms_timer #(
    parameter int unsigned CLK_HZ       = 27000000,
    parameter int unsigned TICKS_PER_MS = CLK_HZ / 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] time_ms,
    input  logic        start,
    input  logic        irq_enable,
    output logic        done,
    output logic        busy,
    output logic        irq
);
    localparam int unsigned PRESC_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICKS_PER_MS - 1);

    logic               start_q, start_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [15:0]        remaining_q, remaining_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               irq_q, irq_d;
    logic               start_edge;

    assign start_edge = start & ~start_q;

    always_comb begin
        start_d     = start;
        presc_d     = presc_q;
        remaining_d = remaining_q;
        busy_d      = busy_q;
        done_d      = done_q;
        irq_d       = 1'b0;

        // A start edge outranks everything, including an expiry in the same cycle.
        if (start_edge) begin
            presc_d = '0;
            if (time_ms != 16'd0) begin
                remaining_d = time_ms;
                busy_d      = 1'b1;
                done_d      = 1'b0;
            end else begin
                remaining_d = 16'd0;
                busy_d      = 1'b0;
                done_d      = 1'b1;
                irq_d       = irq_enable;
            end
        end else if (busy_q) begin
            if (presc_q == PRESC_MAX) begin
                presc_d = '0;
                if (remaining_q == 16'd1) begin
                    remaining_d = 16'd0;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    irq_d       = irq_enable;
                end else begin
                    remaining_d = remaining_q - 16'd1;
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            start_q     <= 1'b0;
            presc_q     <= '0;
            remaining_q <= 16'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            start_q     <= start_d;
            presc_q     <= presc_d;
            remaining_q <= remaining_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            irq_q       <= irq_d;
        end
    end

    assign done = done_q;
    assign busy = busy_q;
    assign irq  = irq_q;
endmodule
